// File: rtl/fifo_serializer_tx_if.sv
// FIFO read-port bundle between the async FIFO and the serial transmit stage.
// master = the serializer (issues pops), slave = the FIFO side.
interface fifo_serializer_tx_if #(
    parameter int WIDTH = 8
) ();
    logic             empty_i;
    logic [WIDTH-1:0] r_data_i;
    logic             rd_error_i;
    logic             rd_en_o;

    modport master (
        input  empty_i,
        input  r_data_i,
        input  rd_error_i,
        output rd_en_o
    );

    modport slave (
        output empty_i,
        output r_data_i,
        output rd_error_i,
        input  rd_en_o
    );
endinterface

// File: rtl/fifo_serializer_tx.sv
// Serial transmit stage: pops one word from the FIFO and sends it as
// start bit, data LSB-first, optional parity, stop bit on an idle-high line.
module fifo_serializer_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_WIDTH    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fifo_serializer_tx_if.master fifo,
    output logic                ser_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic                underflow_o
);
    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t               r_state, w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic [IDX_W-1:0]     r_idx, w_idx_next;
    logic [WIDTH-1:0]     r_shift, w_shift_next;
    logic                 r_parity, w_parity_next;
    logic                 r_ser, w_ser_next;
    logic                 r_rd_en, w_rd_en_next;
    logic                 r_busy, w_busy_next;
    logic                 r_frame_done, w_frame_done_next;
    logic                 r_underflow, w_underflow_next;
    logic                 w_cnt_last;
    logic                 w_counting;

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_cnt_last    = (r_cnt == CNT_LAST);
        w_counting    = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PARITY) || (r_state == S_STOP);

        case (r_state)
            S_IDLE:   if (!fifo.empty_i) w_state_next = S_POP;
            S_POP:    w_state_next = S_LOAD;
            S_LOAD: begin
                w_shift_next  = fifo.r_data_i;
                w_parity_next = (^fifo.r_data_i) ^ 1'(PARITY_ODD);
                w_state_next  = S_START;
            end
            S_START: begin
                if (w_cnt_last) begin
                    w_state_next = S_DATA;
                    w_idx_next   = '0;
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_next   = r_idx + 1'b1;
                        w_shift_next = r_shift >> 1;
                    end
                end
            end
            S_PARITY: if (w_cnt_last) w_state_next = S_STOP;
            S_STOP:   if (w_cnt_last) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase

        // Counter restarts at every bit boundary, which also covers every state entry.
        w_cnt_next = (w_counting && !w_cnt_last) ? r_cnt + 1'b1 : '0;

        // Outputs are computed from next-state values so the registered copies line up with r_state.
        case (w_state_next)
            S_START:  w_ser_next = 1'b0;
            S_DATA:   w_ser_next = w_shift_next[0];
            S_PARITY: w_ser_next = w_parity_next;
            default:  w_ser_next = 1'b1;
        endcase
        w_rd_en_next      = (w_state_next == S_POP);
        w_busy_next       = (w_state_next != S_IDLE);
        w_frame_done_next = (w_state_next == S_STOP) && (w_cnt_next == CNT_LAST);
        w_underflow_next  = r_underflow | fifo.rd_error_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_ser        <= 1'b1;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_shift      <= w_shift_next;
            r_parity     <= w_parity_next;
            r_ser        <= w_ser_next;
            r_rd_en      <= w_rd_en_next;
            r_busy       <= w_busy_next;
            r_frame_done <= w_frame_done_next;
            r_underflow  <= w_underflow_next;
        end
    end

    assign fifo.rd_en_o = r_rd_en;
    assign ser_o        = r_ser;
    assign busy_o       = r_busy;
    assign frame_done_o = r_frame_done;
    assign underflow_o  = r_underflow;
endmodule

// File: tb/tb_fifo_serializer_tx.sv
// Directed bench: three serializers (even parity, odd parity, no parity) share
// one FIFO stimulus; each frame is captured clock-by-clock and compared.
module tb_fifo_serializer_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       empty;
    logic [7:0] data;
    logic       rd_err;

    fifo_serializer_tx_if #(.WIDTH(8)) if0 ();
    fifo_serializer_tx_if #(.WIDTH(8)) if1 ();
    fifo_serializer_tx_if #(.WIDTH(8)) if2 ();

    assign if0.empty_i = empty;  assign if0.r_data_i = data;  assign if0.rd_error_i = rd_err;
    assign if1.empty_i = empty;  assign if1.r_data_i = data;  assign if1.rd_error_i = rd_err;
    assign if2.empty_i = empty;  assign if2.r_data_i = data;  assign if2.rd_error_i = rd_err;

    logic [2:0] ser, busy, done, uflow;
    wire  [2:0] rd_en = {if2.rd_en_o, if1.rd_en_o, if0.rd_en_o};

    fifo_serializer_tx u_even (
        .clk_i(clk), .rst_i(rst_n), .fifo(if0.master),
        .ser_o(ser[0]), .busy_o(busy[0]), .frame_done_o(done[0]), .underflow_o(uflow[0])
    );
    fifo_serializer_tx #(.PARITY_ODD(1)) u_odd (
        .clk_i(clk), .rst_i(rst_n), .fifo(if1.master),
        .ser_o(ser[1]), .busy_o(busy[1]), .frame_done_o(done[1]), .underflow_o(uflow[1])
    );
    fifo_serializer_tx #(.PARITY_EN(0)) u_nopar (
        .clk_i(clk), .rst_i(rst_n), .fifo(if2.master),
        .ser_o(ser[2]), .busy_o(busy[2]), .frame_done_o(done[2]), .underflow_o(uflow[2])
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected serial line, one bit per clock, idle-high after the frame.
    function automatic logic [63:0] exp_ser(input logic [7:0] w, input bit pen, input bit podd);
        logic [63:0] v;
        logic [11:0] b;
        int nb;
        v = '1;
        b = '0;
        b[0] = 1'b0;
        for (int k = 0; k < 8; k++) b[k+1] = w[k];
        nb = 9;
        if (pen) begin
            b[9] = (^w) ^ podd;
            nb = 10;
        end
        b[nb] = 1'b1;
        nb++;
        for (int k = 0; k < nb; k++)
            for (int c = 0; c < 4; c++) v[k*4+c] = b[k];
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Waits (bounded) for the pop pulse; returns at the negedge where rd_en_o is high.
    task automatic wait_pop(input string tag);
        int lat;
        bit found;
        found = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (rd_en[0]) begin
                found = 1'b1;
                lat = k;
                break;
            end
        end
        chk({tag, "_pop_seen"}, 64'(found), 64'd1);
        chk({tag, "_pop_lat"}, 64'(lat), 64'd1);
    endtask

    // Entered at the POP-cycle negedge; checks the whole frame on all three DUTs.
    task automatic run_frame(input logic [7:0] w);
        logic [63:0] s0, s1, s2, d0, d1, d2, b0, b2;
        s0 = '1; s1 = '1; s2 = '1;
        d0 = '0; d1 = '0; d2 = '0; b0 = '0; b2 = '0;
        empty = 1'b1;
        chk("pop_rden", 64'(rd_en), 64'h7);
        chk("pop_busy", 64'(busy), 64'h7);
        step();
        chk("load_rden", 64'(rd_en), 64'h0);
        chk("load_busy", 64'(busy), 64'h7);
        step();
        for (int i = 0; i < 48; i++) begin
            s0[i] = ser[0]; s1[i] = ser[1]; s2[i] = ser[2];
            d0[i] = done[0]; d1[i] = done[1]; d2[i] = done[2];
            b0[i] = busy[0]; b2[i] = busy[2];
            step();
        end
        chk("ser_even", s0, exp_ser(w, 1'b1, 1'b0));
        chk("ser_odd",  s1, exp_ser(w, 1'b1, 1'b1));
        chk("ser_nopar", s2, exp_ser(w, 1'b0, 1'b0));
        chk("done_even", d0, 64'h1 << 43);
        chk("done_odd",  d1, 64'h1 << 43);
        chk("done_nopar", d2, 64'h1 << 39);
        chk("busy_even", b0, (64'h1 << 44) - 64'h1);
        chk("busy_nopar", b2, (64'h1 << 40) - 64'h1);
        $display("frame word=%02h checked total=%0d bad=%0d", w, n_total, n_bad);
    endtask

    initial begin
        logic [63:0] va, vb;
        logic [2:0]  any_rd, any_busy, all_ser;
        int          pops, pop_pos;

        // Reset held with a non-empty FIFO: nothing may move.
        rst_n = 1'b0; empty = 1'b0; data = 8'hA5; rd_err = 1'b0;
        any_rd = '0; any_busy = '0; all_ser = '1;
        for (int i = 0; i < 5; i++) begin
            step();
            any_rd |= rd_en; any_busy |= busy; all_ser &= ser;
        end
        chk("rst_rden", 64'(any_rd), 64'h0);
        chk("rst_busy", 64'(any_busy), 64'h0);
        chk("rst_ser", 64'(all_ser), 64'h7);
        chk("rst_uflow", 64'(uflow), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        rst_n = 1'b1;
        wait_pop("rst_rel");
        run_frame(8'hA5);

        data = 8'h01; empty = 1'b0;
        wait_pop("w01");
        run_frame(8'h01);

        data = 8'hFF; empty = 1'b0;
        wait_pop("wFF");
        run_frame(8'hFF);

        // Back-to-back pair, checked on the even-parity DUT.
        data = 8'h3C; empty = 1'b0;
        wait_pop("b2b");
        step();
        step();
        data = 8'hC3;
        va = '1; vb = '1; pops = 0; pop_pos = -1;
        for (int i = 0; i < 100; i++) begin
            if (i < 47) va[i] = ser[0];
            else        vb[i-47] = ser[0];
            if (rd_en[0]) begin
                pops++;
                pop_pos = i;
                empty = 1'b1;
            end
            step();
        end
        chk("b2b_frame1", va, exp_ser(8'h3C, 1'b1, 1'b0));
        chk("b2b_frame2", vb, exp_ser(8'hC3, 1'b1, 1'b0));
        chk("b2b_pops", 64'(pops), 64'd1);
        chk("b2b_pop_pos", 64'(pop_pos), 64'd45);
        $display("b2b words=3C,C3 checked total=%0d bad=%0d", n_total, n_bad);

        // FIFO stays empty: no pops, line idles high.
        empty = 1'b1; any_rd = '0; all_ser = '1;
        for (int i = 0; i < 30; i++) begin
            step();
            any_rd |= rd_en; all_ser &= ser;
        end
        chk("empty_rden", 64'(any_rd), 64'h0);
        chk("empty_ser", 64'(all_ser), 64'h7);
        chk("pre_uflow", 64'(uflow), 64'h0);

        rd_err = 1'b1;
        step();
        rd_err = 1'b0;
        chk("uflow_set", 64'(uflow), 64'h7);
        repeat (10) step();
        chk("uflow_sticky", 64'(uflow), 64'h7);
        $display("underflow checked total=%0d bad=%0d", n_total, n_bad);

        // Reset in the middle of data bit 3 of 0xA5 (that bit is 0).
        data = 8'hA5; empty = 1'b0;
        wait_pop("mid");
        empty = 1'b1;
        step();
        step();
        repeat (17) step();
        chk("mid_pre_ser", 64'(ser), 64'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ser", 64'(ser), 64'h7);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_uflow", 64'(uflow), 64'h0);
        repeat (2) step();
        rst_n = 1'b1;
        data = 8'h3C; empty = 1'b0;
        wait_pop("post_rst");
        run_frame(8'h3C);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
